// File: rtl/dmem_responder.sv
// Data-memory responder: turns one pipeline load/store request into a single memory-side
// access, waits for mem_ready (or a timeout), then pulses completion and returns the loaded word.
module dmem_responder #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_CEB,
  input  logic        DM_WEB,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  is_store,
  input  logic [2:0]  is_load,
  output logic [1:0]  busStall,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    lo;
  logic [2:0]    ld_q;

  logic          mis;
  logic [3:0]    strb;
  logic [31:0]   wd;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_ext;

  assign busStall[1] = ((state == IDLE) && !DM_CEB) || (state == ACCESS);
  assign busStall[0] = (state == DONE);

  always_comb begin
    mis = 1'b0;
    if (!DM_WEB) begin
      case (is_store)
        2'b10:   mis = addr[0];
        2'b11:   mis = 1'b0;
        default: mis = |addr[1:0];
      endcase
    end else begin
      case (is_load)
        3'b001, 3'b101: mis = 1'b0;
        3'b010, 3'b100: mis = addr[0];
        default:        mis = |addr[1:0];
      endcase
    end
  end

  always_comb begin
    strb = 4'b1111;
    wd   = wdata;
    case (is_store)
      2'b10: begin
        strb = addr[1] ? 4'b1100 : 4'b0011;
        wd   = {2{wdata[15:0]}};
      end
      2'b11: begin
        strb = 4'b0001 << addr[1:0];
        wd   = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    if (DM_WEB) strb = 4'b0000;
  end

  // lane selection uses the captured low address bits, not the live bus
  always_comb begin
    lane_b = mem_rdata[{lo, 3'b000} +: 8];
    lane_h = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_q)
      3'b001:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b010:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_ext = {16'h0, lane_h};
      3'b101:  ld_ext = {24'h0, lane_b};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lo        <= '0;
      ld_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        ACCESS: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (!mem_we) rdata <= ld_ext;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (!mem_we) rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus_err  <= 1'b0;
          misalign <= 1'b0;
        end
        default: begin
          if (!DM_CEB) begin
            mem_addr  <= {addr[31:2], 2'b00};
            lo        <= addr[1:0];
            ld_q      <= is_load;
            mem_we    <= !DM_WEB && !mis;
            mem_wstrb <= mis ? 4'b0000 : strb;
            mem_wdata <= wd;
            cnt       <= '0;
            if (mis) begin
              state    <= DONE;
              misalign <= 1'b1;
              if (DM_WEB) rdata <= '0;
            end else begin
              state   <= ACCESS;
              mem_req <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads, stores, misalign, timeout and reset abort.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst, DM_CEB, DM_WEB;
  logic [31:0] addr, wdata;
  logic [1:0]  is_store;
  logic [2:0]  is_load;
  logic [1:0]  busStall;
  logic [31:0] rdata;
  logic        bus_err, misalign, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  dmem_responder #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .DM_CEB(DM_CEB), .DM_WEB(DM_WEB), .addr(addr), .wdata(wdata),
    .is_store(is_store), .is_load(is_load), .busStall(busStall), .rdata(rdata),
    .bus_err(bus_err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic web, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] st, input logic [2:0] ld);
    DM_CEB = 1'b0; DM_WEB = web; addr = a; wdata = wd; is_store = st; is_load = ld;
  endtask

  task automatic release_req();
    DM_CEB = 1'b1; mem_ready = 1'b0;
  endtask

  // one load with mem_ready on the first ACCESS cycle; returns what DONE shows
  task automatic do_load(input logic [31:0] a, input logic [2:0] ld, input logic [31:0] word,
                         output logic [31:0] r, output logic [1:0] bs);
    req(1'b1, a, 32'h0, 2'b00, ld);
    mem_ready = 1'b1; mem_rdata = word;
    step(); step();
    r = rdata; bs = busStall;
    release_req(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; DM_CEB = 1'b1; DM_WEB = 1'b1; addr = 32'h0; wdata = 32'h0;
    is_store = 2'b00; is_load = 3'b000; mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    rst = 1'b0; #1;
    n_chk++; if (busStall !== 2'b00) begin n_fail++; $display("FAIL reset_busStall: got %b want 00", busStall); end
    n_chk++; if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 000000", {mem_req, mem_we, mem_wstrb}); end
    n_chk++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", mem_addr, mem_wdata, rdata); end
    n_chk++; if ({bus_err, misalign} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus_err, misalign}); end
  endtask

  task automatic test_lw();
    req(1'b1, 32'h100, 32'h0, 2'b00, 3'b011);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    n_chk++; if (busStall !== 2'b10) begin n_fail++; $display("FAIL lw_c1_busStall: got %b want 10", busStall); end
    step();
    n_chk++; if ({mem_req, mem_we, mem_wstrb} !== 6'b100000) begin n_fail++; $display("FAIL lw_access_ctl: got %b want 100000", {mem_req, mem_we, mem_wstrb}); end
    n_chk++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", mem_addr); end
    n_chk++; if (busStall !== 2'b10) begin n_fail++; $display("FAIL lw_c2_busStall: got %b want 10", busStall); end
    step();
    n_chk++; if (busStall !== 2'b01) begin n_fail++; $display("FAIL lw_done_busStall: got %b want 01", busStall); end
    n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rdata); end
    n_chk++; if ({bus_err, misalign} !== 2'b00) begin n_fail++; $display("FAIL lw_flags: got %b want 00", {bus_err, misalign}); end
    release_req(); step();
    n_chk++; if (busStall !== 2'b00) begin n_fail++; $display("FAIL lw_idle_busStall: got %b want 00", busStall); end
  endtask

  task automatic test_sb();
    req(1'b0, 32'h203, 32'h000000A5, 2'b11, 3'b000);
    mem_ready = 1'b0;
    step();
    n_chk++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL sb_req_we: got %b want 11", {mem_req, mem_we}); end
    n_chk++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_addr: got %h want 00000200", mem_addr); end
    n_chk++; if (mem_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_strb: got %b want 1000", mem_wstrb); end
    n_chk++; if (mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); end
    mem_ready = 1'b1; step();
    n_chk++; if (busStall !== 2'b01) begin n_fail++; $display("FAIL sb_done: got %b want 01", busStall); end
    n_chk++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sb_rdata_hold: got %h want deadbeef", rdata); end
    release_req(); step();
  endtask

  task automatic test_loads();
    logic [31:0] r;
    logic [1:0]  bs;
    do_load(32'h2, 3'b001, 32'h00800000, r, bs);
    n_chk++; if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h want ffffff80", r); end
    n_chk++; if (bs !== 2'b01) begin n_fail++; $display("FAIL lb_done: got %b want 01", bs); end
    do_load(32'h2, 3'b101, 32'h00800000, r, bs);
    n_chk++; if (r !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", r); end
    do_load(32'h6, 3'b010, 32'h80017F00, r, bs);
    n_chk++; if (r !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sext: got %h want ffff8001", r); end
    do_load(32'h4, 3'b100, 32'h1234F00D, r, bs);
    n_chk++; if (r !== 32'h0000F00D) begin n_fail++; $display("FAIL lhu_zext: got %h want 0000f00d", r); end
    do_load(32'h8, 3'b000, 32'h13579BDF, r, bs);
    n_chk++; if (r !== 32'h13579BDF) begin n_fail++; $display("FAIL ld000_as_lw: got %h want 13579bdf", r); end
  endtask

  task automatic test_misalign();
    req(1'b0, 32'h101, 32'h00001234, 2'b10, 3'b000);
    #1;
    n_chk++; if (busStall !== 2'b10) begin n_fail++; $display("FAIL mis_c1_busStall: got %b want 10", busStall); end
    step();
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %b want 0", mem_req); end
    n_chk++; if (busStall !== 2'b01) begin n_fail++; $display("FAIL mis_done: got %b want 01", busStall); end
    n_chk++; if ({misalign, bus_err} !== 2'b10) begin n_fail++; $display("FAIL mis_flags: got %b want 10", {misalign, bus_err}); end
    release_req(); step();
    n_chk++; if ({busStall, misalign, mem_req} !== 4'b0000) begin n_fail++; $display("FAIL mis_after: got %b want 0000", {busStall, misalign, mem_req}); end
    req(1'b1, 32'h1, 32'h0, 2'b00, 3'b011);
    step();
    n_chk++; if ({misalign, rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL mis_lw_rdata: got %b %h want 1 00000000", misalign, rdata); end
    release_req(); step();
  endtask

  task automatic test_sh();
    req(1'b0, 32'h102, 32'h0000BEEF, 2'b10, 3'b000);
    step();
    n_chk++; if (mem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_strb: got %b want 1100", mem_wstrb); end
    n_chk++; if (mem_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", mem_wdata); end
    mem_ready = 1'b1; step();
    release_req(); step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat = 6'b0;
    req(1'b0, 32'h300, 32'hCAFEF00D, 2'b01, 3'b000);
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[4:0], busStall[0]};
      if (i == 1) begin
        n_chk++; if ({mem_wstrb, mem_wdata} !== {4'b1111, 32'hCAFEF00D}) begin n_fail++; $display("FAIL b2b_sw: got %b %h want 1111 cafef00d", mem_wstrb, mem_wdata); end
      end
      step();
    end
    release_req();
    n_chk++; if (pat !== 6'b001001) begin n_fail++; $display("FAIL b2b_pattern: got %b want 001001", pat); end
    step();
  endtask

  task automatic test_timeout();
    int k = 0;
    req(1'b1, 32'h0, 32'h0, 2'b00, 3'b011);
    mem_ready = 1'b0;
    step();
    while (mem_req === 1'b1 && k < 40) begin k++; step(); end
    n_chk++; if (k !== 16) begin n_fail++; $display("FAIL to_cycles: got %0d want 16", k); end
    n_chk++; if ({busStall, bus_err} !== 3'b011) begin n_fail++; $display("FAIL to_done: got %b want 011", {busStall, bus_err}); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 00000000", rdata); end
    release_req(); step();
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b want 0", bus_err); end
  endtask

  task automatic test_ready_wins();
    req(1'b1, 32'h10, 32'h0, 2'b00, 3'b011);
    mem_ready = 1'b0;
    step();
    repeat (15) step();
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rw_still_access: got %b want 1", mem_req); end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    n_chk++; if ({busStall, bus_err} !== 3'b010) begin n_fail++; $display("FAIL rw_done: got %b want 010", {busStall, bus_err}); end
    n_chk++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL rw_rdata: got %h want 12345678", rdata); end
    release_req(); step();
  endtask

  task automatic test_reset_in_access();
    req(1'b1, 32'h40, 32'h0, 2'b00, 3'b011);
    mem_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; DM_CEB = 1'b1; #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_acc_req: got %b want 0", mem_req); end
    n_chk++; if (busStall !== 2'b00) begin n_fail++; $display("FAIL rst_acc_busStall: got %b want 00", busStall); end
    n_chk++; if ({rdata, bus_err} !== 33'h0) begin n_fail++; $display("FAIL rst_acc_out: got %h %b want 0", rdata, bus_err); end
    step();
    n_chk++; if ({busStall, mem_req} !== 3'b000) begin n_fail++; $display("FAIL rst_acc_idle: got %b want 000", {busStall, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_loads();
    test_misalign();
    test_sh();
    test_back_to_back();
    test_timeout();
    test_ready_wins();
    test_reset_in_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
